// File: rtl/vec_int_ctrl.sv
// vec_int_ctrl: parametrised vectored interrupt controller beside CP0.
// Per-line mask, edge/level select, pending latch, fixed priority (bit 0
// highest), EPC/EXL/CAUSE capture and a per-line vector for the PC mux.
// Optional macro VEC_INT_SYNC_EN adds a 2-flop synchroniser on every irq bit.
module vec_int_ctrl #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h200,
  parameter logic [31:0] VEC_STRIDE = 32'h20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               we,
  input  logic [4:0]         addr,
  input  logic [31:0]        wd,
  output logic [31:0]        rd,
  input  logic [31:0]        pc_current,
  output logic               int_req,
  output logic [31:0]        vector,
  input  logic               int_ack,
  input  logic               eret,
  output logic [31:0]        epc,
  output logic               exl
);

  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  logic [1:0]         state;
  logic [ID_W-1:0]    id;
  logic               ie;
  logic [NUM_IRQ-1:0] mask, edge_sel, pending, irq_d, irq_s;
  logic [4:0]         cause;

  logic               wr_status, wr_mask, wr_pend, wr_edge, wr_epc;
  logic               ie_nxt, abort, ack_fire, cand_vld;
  logic [NUM_IRQ-1:0] mask_nxt, rise, w1c, ack_clr, pending_nxt;
  logic [ID_W-1:0]    cand;

`ifdef VEC_INT_SYNC_EN
  logic [NUM_IRQ-1:0] irq_meta, irq_sync;

  // Two-flop synchroniser for asynchronous interrupt sources
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_meta <= '0;
      irq_sync <= '0;
    end else begin
      irq_meta <= irq;
      irq_sync <= irq_meta;
    end
  end

  assign irq_s = irq_sync;
`else
  assign irq_s = irq;
`endif

  assign wr_status = we && (addr == 5'd0);
  assign wr_mask   = we && (addr == 5'd1);
  assign wr_pend   = we && (addr == 5'd2);
  assign wr_edge   = we && (addr == 5'd3);
  assign wr_epc    = we && (addr == 5'd4);

  // A write that disables the in-flight line must take effect at this edge,
  // so REQ looks at the values about to be written, not the stored ones.
  assign ie_nxt   = wr_status ? wd[0] : ie;
  assign mask_nxt = wr_mask ? wd[NUM_IRQ-1:0] : mask;
  assign abort    = (state == S_REQ) && (!ie_nxt || !mask_nxt[id]);
  assign ack_fire = (state == S_REQ) && int_ack && !abort;

  assign rise = irq_s & ~irq_d;
  assign w1c  = wr_pend ? (wd[NUM_IRQ-1:0] & edge_sel) : '0;

  // Pending next-state: edge lines latch rises (rise beats any clear),
  // level lines simply mirror the registered irq
  always_comb begin
    ack_clr = '0;
    if (ack_fire)
      ack_clr[id] = edge_sel[id];
    pending_nxt = (edge_sel & ((pending & ~w1c & ~ack_clr) | rise)) |
                  (~edge_sel & irq_s);
  end

  // Fixed priority: scan downward so the lowest active index wins
  always_comb begin
    cand     = '0;
    cand_vld = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i] && mask[i]) begin
        cand     = ID_W'(i);
        cand_vld = 1'b1;
      end
    end
  end

  // Software-visible registers and pending latch
  always_ff @(posedge clk) begin
    if (!rst) begin
      ie       <= 1'b0;
      mask     <= '0;
      edge_sel <= '0;
      pending  <= '0;
      irq_d    <= '0;
      epc      <= '0;
      cause    <= '0;
    end else begin
      ie       <= ie_nxt;
      mask     <= mask_nxt;
      irq_d    <= irq_s;
      pending  <= pending_nxt;
      if (wr_edge)
        edge_sel <= wd[NUM_IRQ-1:0];
      if (ack_fire) begin
        epc   <= pc_current;
        cause <= 5'(id);
      end else if (wr_epc) begin
        epc <= wd;
      end
    end
  end

  // Request/service FSM; id is frozen once REQ is entered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      id    <= '0;
      exl   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ie && !exl && cand_vld) begin
            state <= S_REQ;
            id    <= cand;
          end
        end
        S_REQ: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (int_ack) begin
            state <= S_SVC;
            exl   <= 1'b1;
          end
        end
        S_SVC: begin
          if (eret) begin
            state <= S_IDLE;
            exl   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign int_req = (state == S_REQ);
  assign vector  = VEC_BASE + 32'(id) * VEC_STRIDE;

  // Combinational register read port; unmapped addresses read zero
  always_comb begin
    rd = '0;
    case (addr)
      5'd0: rd[1:0] = {exl, ie};
      5'd1: rd[NUM_IRQ-1:0] = mask;
      5'd2: rd[NUM_IRQ-1:0] = pending;
      5'd3: rd[NUM_IRQ-1:0] = edge_sel;
      5'd4: rd = epc;
      5'd5: rd[4:0] = cause;
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_vec_int_ctrl.sv
// Self-checking bench for vec_int_ctrl (NUM_IRQ=8, default parameters).
// Expected vectors are queued when an interrupt is stimulated and popped
// when the DUT raises int_req.
module tb_vec_int_ctrl;

`ifdef VEC_INT_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  irq = '0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd;
  logic [31:0] pc_current = '0;
  logic        int_req;
  logic [31:0] vector;
  logic        int_ack = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc;
  logic        exl;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  vec_int_ctrl #(.NUM_IRQ(8), .VEC_BASE(32'h200), .VEC_STRIDE(32'h20)) dut (
    .clk(clk), .rst(rst), .irq(irq), .we(we), .addr(addr), .wd(wd), .rd(rd),
    .pc_current(pc_current), .int_req(int_req), .vector(vector),
    .int_ack(int_ack), .eret(eret), .epc(epc), .exl(exl)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wd = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
    addr = a;
    #1 v = rd;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (int_req) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_ack(input logic [31:0] pc);
    int_ack = 1'b1; pc_current = pc;
    @(negedge clk);
    int_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b0; irq = 8'hFF;
    repeat (3) @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      we = 1'b1; wd = 32'hFFFF_FFFF;
      rd_reg(5'(a), v);
      n_cmp++;
      if (v !== 32'h0) begin n_err++; $display("FAIL reset_rd[%0d]: got %h expected %h", a, v, 32'h0); end
      @(negedge clk);
    end
    we = 1'b0;
    n_cmp++;
    if (int_req !== 1'b0) begin n_err++; $display("FAIL reset_int_req: got %b expected 0", int_req); end
    n_cmp++;
    if (vector !== 32'h200) begin n_err++; $display("FAIL reset_vector: got %h expected %h", vector, 32'h200); end
    n_cmp++;
    if (exl !== 1'b0) begin n_err++; $display("FAIL reset_exl: got %b expected 0", exl); end
    irq = '0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_edge();
    logic [31:0] v, e;
    bit ok;
    wr(5'd0, 32'h1); wr(5'd1, 32'h08); wr(5'd3, 32'h08);
    exp_q.push_back(32'h260);
    irq = 8'h08;
    @(negedge clk);
    irq = 8'h00;
    for (int c = 1; c < LAT; c++) begin
      n_cmp++;
      if (int_req !== 1'b0) begin n_err++; $display("FAIL edge_early_req: got %b expected 0 at cycle %0d", int_req, c); end
      @(negedge clk);
    end
    n_cmp++;
    if (int_req !== 1'b1) begin n_err++; $display("FAIL edge_latency: got %b expected 1", int_req); end
    e = exp_q.pop_front();
    n_cmp++;
    if (vector !== e) begin n_err++; $display("FAIL edge_vector: got %h expected %h", vector, e); end
    pulse_ack(32'h1040);
    rd_reg(5'd4, v); n_cmp++;
    if (v !== 32'h1040) begin n_err++; $display("FAIL edge_epc: got %h expected %h", v, 32'h1040); end
    rd_reg(5'd5, v); n_cmp++;
    if (v !== 32'd3) begin n_err++; $display("FAIL edge_cause: got %h expected %h", v, 32'd3); end
    rd_reg(5'd2, v); n_cmp++;
    if (v[3] !== 1'b0) begin n_err++; $display("FAIL edge_pending_clr: got %b expected 0", v[3]); end
    n_cmp++;
    if (exl !== 1'b1 || epc !== 32'h1040) begin n_err++; $display("FAIL edge_exl_epc: got exl=%b epc=%h expected exl=1 epc=%h", exl, epc, 32'h1040); end
    pulse_eret();
    n_cmp++;
    if (exl !== 1'b0) begin n_err++; $display("FAIL edge_eret_exl: got %b expected 0", exl); end
    wait_req(ok);
    n_cmp++;
    if (ok) begin n_err++; $display("FAIL edge_no_rereq: got int_req=1 expected 0"); end
  endtask

  task automatic test_priority();
    logic [31:0] v, e;
    bit ok;
    wr(5'd1, 32'h24); wr(5'd3, 32'h24);
    exp_q.push_back(32'h240);
    exp_q.push_back(32'h2A0);
    irq = 8'h24;
    @(negedge clk);
    irq = 8'h00;
    for (int k = 0; k < 2; k++) begin
      wait_req(ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL prio_timeout[%0d]: got no int_req expected int_req=1", k); end
      e = exp_q.pop_front();
      n_cmp++;
      if (vector !== e) begin n_err++; $display("FAIL prio_vector[%0d]: got %h expected %h", k, vector, e); end
      pulse_ack(32'h2000 + 32'(k));
      rd_reg(5'd5, v); n_cmp++;
      if (v !== ((k == 0) ? 32'd2 : 32'd5)) begin n_err++; $display("FAIL prio_cause[%0d]: got %h expected %h", k, v, (k == 0) ? 32'd2 : 32'd5); end
      pulse_eret();
    end
  endtask

  task automatic test_level_hold();
    logic [31:0] v, e;
    bit ok;
    wr(5'd3, 32'h00); wr(5'd1, 32'h02);
    exp_q.push_back(32'h220);
    exp_q.push_back(32'h220);
    irq = 8'h02;
    wait_req(ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL level_timeout: got no int_req expected int_req=1"); end
    e = exp_q.pop_front();
    n_cmp++;
    if (vector !== e) begin n_err++; $display("FAIL level_vector: got %h expected %h", vector, e); end
    pulse_ack(32'h3000);
    pulse_eret();
    n_cmp++;
    if (int_req !== 1'b0) begin n_err++; $display("FAIL level_idle_gap: got %b expected 0", int_req); end
    @(negedge clk);
    n_cmp++;
    if (int_req !== 1'b1) begin n_err++; $display("FAIL level_rereq: got %b expected 1", int_req); end
    e = exp_q.pop_front();
    n_cmp++;
    if (vector !== e) begin n_err++; $display("FAIL level_rereq_vector: got %h expected %h", vector, e); end
    pulse_ack(32'h3004);
    irq = 8'h00;
    repeat (LAT) @(negedge clk);
    rd_reg(5'd2, v); n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL level_pending_drop: got %h expected 0", v); end
    pulse_eret();
    wait_req(ok);
    n_cmp++;
    if (ok) begin n_err++; $display("FAIL level_no_rereq: got int_req=1 expected 0"); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] v, e;
    bit ok;
    wr(5'd1, 32'h10); wr(5'd3, 32'h10);
    exp_q.push_back(32'h280);
    irq = 8'h10;
    @(negedge clk);
    irq = 8'h00;
    wait_req(ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || vector !== e) begin n_err++; $display("FAIL w1c_setup_req: got req=%b vector=%h expected req=1 vector=%h", ok, vector, e); end
    pulse_ack(32'h4000);
    irq = 8'h10;
    for (int c = 2; c < LAT; c++) @(negedge clk);
    wr(5'd2, 32'h10);
    repeat (2) @(negedge clk);
    rd_reg(5'd2, v); n_cmp++;
    if (v[4] !== 1'b1) begin n_err++; $display("FAIL w1c_set_wins: got %b expected 1", v[4]); end
    n_cmp++;
    if (int_req !== 1'b0) begin n_err++; $display("FAIL w1c_svc_holds: got %b expected 0", int_req); end
    wr(5'd2, 32'h10);
    rd_reg(5'd2, v); n_cmp++;
    if (v[4] !== 1'b0) begin n_err++; $display("FAIL w1c_clear: got %b expected 0", v[4]); end
    irq = 8'h00;
    pulse_eret();
    wait_req(ok);
    n_cmp++;
    if (ok) begin n_err++; $display("FAIL w1c_no_rereq: got int_req=1 expected 0"); end
  endtask

  task automatic test_abort();
    logic [31:0] v, e;
    bit ok;
    wr(5'd1, 32'h01); wr(5'd3, 32'h01);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h200);
    irq = 8'h01;
    @(negedge clk);
    irq = 8'h00;
    wait_req(ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || vector !== e) begin n_err++; $display("FAIL abort_setup_req: got req=%b vector=%h expected req=1 vector=%h", ok, vector, e); end
    wr(5'd0, 32'h0);
    n_cmp++;
    if (int_req !== 1'b0) begin n_err++; $display("FAIL abort_drop: got %b expected 0", int_req); end
    rd_reg(5'd2, v); n_cmp++;
    if (v !== 32'h01) begin n_err++; $display("FAIL abort_pending_kept: got %h expected %h", v, 32'h01); end
    wr(5'd0, 32'h1);
    wait_req(ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || vector !== e) begin n_err++; $display("FAIL abort_rereq: got req=%b vector=%h expected req=1 vector=%h", ok, vector, e); end
    pulse_ack(32'h5000);
    n_cmp++;
    if (exl !== 1'b1) begin n_err++; $display("FAIL abort_svc_exl: got %b expected 1", exl); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (exl !== 1'b0 || int_req !== 1'b0) begin n_err++; $display("FAIL abort_midsvc_reset: got exl=%b req=%b expected 0 0", exl, int_req); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ignored();
    logic [31:0] v;
    int_ack = 1'b1; eret = 1'b1; pc_current = 32'hDEAD_BEEF;
    @(negedge clk);
    int_ack = 1'b0; eret = 1'b0;
    rd_reg(5'd4, v); n_cmp++;
    if (v !== 32'h0) begin n_err++; $display("FAIL stray_ack_epc: got %h expected 0", v); end
    n_cmp++;
    if (exl !== 1'b0 || int_req !== 1'b0) begin n_err++; $display("FAIL stray_ack_state: got exl=%b req=%b expected 0 0", exl, int_req); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_edge();
    test_priority();
    test_level_hold();
    test_w1c_race();
    test_abort();
    test_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
